// File: rtl/clb_param.sv
// Parameterised configurable logic block: N_LUT LUT/flip-flop channels
// programmed through a daisy-chainable serial configuration shift register.
module clb_param #(
  parameter int LUT_K = 4,
  parameter int N_LUT = 2
) (
  input  logic             K,
  input  logic             RST_N,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DOUT,
  output logic             CFG_DONE,
  input  logic [LUT_K-1:0] IN,
  input  logic             CE,
  input  logic             SR,
  output logic [N_LUT-1:0] O
);

  localparam int T        = 2 ** LUT_K;
  localparam int W        = T + 4;
  localparam int CFG_BITS = N_LUT * W;
  localparam int CW       = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    UNCFG,
    LOAD,
    ACTIVE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic [CFG_BITS-1:0] cfg;
  logic [N_LUT-1:0]    q;
  logic [N_LUT-1:0]    q_nx;
  logic [N_LUT-1:0]    f;
  logic [N_LUT-1:0]    o_act;
  logic                clr_q;
  logic                done_q;

  // Load sequencing: count captured bits, abort when enable drops mid-load.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_q    = 1'b0;
    unique case (state)
      UNCFG, ACTIVE: begin
        if (CFG_EN) begin
          state_nx = LOAD;
          cnt_nx   = CW'(1);
          clr_q    = 1'b1;
        end
      end
      LOAD: begin
        if (!CFG_EN) begin
          state_nx = UNCFG;
          cnt_nx   = '0;
        end else if (cnt == CW'(CFG_BITS - 1)) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = UNCFG;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, bit counter and registered done flag.
  always_ff @(posedge K) begin
    if (!RST_N) begin
      state  <= UNCFG;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= (state_nx == ACTIVE);
    end
  end

  // Configuration shift register, first bit in ends up at the MSB.
  always_ff @(posedge K) begin
    if (!RST_N) begin
      cfg <= '0;
    end else if (CFG_EN) begin
      cfg <= {cfg[CFG_BITS-2:0], CFG_DIN};
    end
  end

  for (genvar i = 0; i < N_LUT; i++) begin : g_ch
    logic [W-1:0]     ch;
    logic [T-1:0]     tt;
    logic [LUT_K-1:0] addr;
    logic [1:0]       srm;

    assign ch   = cfg[i*W +: W];
    assign tt   = ch[T-1:0];
    assign srm  = ch[T+3:T+2];
    assign addr = ch[T+1] ? {q[i], IN[LUT_K-2:0]} : IN;
    assign f[i] = tt[addr];

    assign q_nx[i] = (SR && srm == 2'b01) ? 1'b0 :
                     (SR && srm == 2'b10) ? 1'b1 : f[i];

    assign o_act[i] = ch[T] ? q[i] : f[i];
  end

  // Channel flip-flops: cleared when a new load starts, clocked in ACTIVE.
  always_ff @(posedge K) begin
    if (!RST_N) begin
      q <= '0;
    end else if (clr_q) begin
      q <= '0;
    end else if (state == ACTIVE && CE) begin
      q <= q_nx;
    end
  end

  assign O        = (state == ACTIVE) ? o_act : '0;
  assign CFG_DOUT = cfg[CFG_BITS-1];
  assign CFG_DONE = done_q;

endmodule

// File: tb/tb_clb_param.sv
// Bench for clb_param (LUT_K=4, N_LUT=2): directed scenarios plus
// randomized traffic against a behavioural model of the block.
module tb_clb_param;

  logic       K = 1'b0;
  logic       RST_N = 1'b0;
  logic       CFG_EN = 1'b0;
  logic       CFG_DIN = 1'b0;
  logic       CFG_DOUT;
  logic       CFG_DONE;
  logic [3:0] IN = '0;
  logic       CE = 1'b0;
  logic       SR = 1'b0;
  logic [1:0] O;

  int n_chk = 0;
  int n_err = 0;

  // Model: raw config bits, bits seen in current burst, configured flag, Qs.
  logic [39:0] m_cfg = '0;
  int          m_burst = 0;
  logic        m_done = 1'b0;
  logic [1:0]  m_q = '0;

  clb_param #(.LUT_K(4), .N_LUT(2)) dut (
    .K(K), .RST_N(RST_N), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
    .CFG_DOUT(CFG_DOUT), .CFG_DONE(CFG_DONE), .IN(IN), .CE(CE),
    .SR(SR), .O(O)
  );

  always #5 K = ~K;

  function automatic logic [19:0] mk_ch(input logic [15:0] t,
                                        input logic osel,
                                        input logic fb,
                                        input logic [1:0] srm);
    return {srm, fb, osel, t};
  endfunction

  function automatic logic m_f(input int i);
    logic [15:0] t;
    logic [3:0]  a;
    t = m_cfg[i*20 +: 16];
    a = IN;
    if (m_cfg[i*20+17]) a[3] = m_q[i];
    return t[a];
  endfunction

  function automatic logic [1:0] m_out();
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      if (m_done) r[i] = m_cfg[i*20+16] ? m_q[i] : m_f(i);
    return r;
  endfunction

  task automatic model_edge();
    logic [1:0] nq;
    logic [1:0] srm;
    if (!RST_N) begin
      m_cfg = '0; m_burst = 0; m_done = 1'b0; m_q = '0;
    end else if (CFG_EN) begin
      m_cfg = {m_cfg[38:0], CFG_DIN};
      if (m_burst == 0) begin
        m_q = '0;
        m_done = 1'b0;
      end
      m_burst++;
      if (m_burst == 40) begin
        m_done = 1'b1;
        m_burst = 0;
      end
    end else begin
      m_burst = 0;
      if (m_done && CE) begin
        for (int i = 0; i < 2; i++) begin
          srm = m_cfg[i*20+18 +: 2];
          if (SR && srm == 2'b01) nq[i] = 1'b0;
          else if (SR && srm == 2'b10) nq[i] = 1'b1;
          else nq[i] = m_f(i);
        end
        m_q = nq;
      end
    end
  endtask

  task automatic tick();
    @(posedge K);
    model_edge();
    #1;
  endtask

  task automatic load(input logic [39:0] v);
    for (int b = 39; b >= 0; b--) begin
      CFG_EN = 1'b1;
      CFG_DIN = v[b];
      tick();
    end
    CFG_EN = 1'b0;
    CFG_DIN = 1'b0;
  endtask

  localparam logic [39:0] CFG_A = {20'h300FF, 20'h00116};
  localparam logic [39:0] CFG_B = {20'h90000, 20'h4FFFF};
  localparam logic [39:0] CFG_C = {20'h5FFFF, 20'h4FFFF};

  task automatic test_reset();
    RST_N = 1'b0; CFG_EN = 1'b1; CFG_DIN = 1'b1;
    CE = 1'b1; SR = 1'b1; IN = 4'hF;
    tick();
    tick();
    RST_N = 1'b1; CFG_EN = 1'b0; CFG_DIN = 1'b0;
    CE = 1'b0; SR = 1'b0;
    #1;
    n_chk++;
    if ({O, CFG_DONE, CFG_DOUT} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: O=%b done=%b dout=%b, want O=00 done=0 dout=0",
               O, CFG_DONE, CFG_DOUT);
    end
    tick();
    n_chk++;
    if ({O, CFG_DONE, CFG_DOUT} !== {m_out(), m_done, m_cfg[39]}) begin
      n_err++;
      $display("FAIL reset_idle: O=%b done=%b dout=%b, want %b %b %b",
               O, CFG_DONE, CFG_DOUT, m_out(), m_done, m_cfg[39]);
    end
  endtask

  task automatic load_checked(input string nm, input logic [39:0] v);
    for (int b = 39; b >= 0; b--) begin
      CFG_EN = 1'b1;
      CFG_DIN = v[b];
      tick();
      if (b <= 1) begin
        n_chk++;
        if (CFG_DONE !== (b == 0)) begin
          n_err++;
          $display("FAIL %s_done_edge%0d: done=%b, want %b",
                   nm, 40 - b, CFG_DONE, b == 0);
        end
      end
    end
    CFG_EN = 1'b0;
    CFG_DIN = 1'b0;
  endtask

  task automatic test_load_comb();
    CE = 1'b0; SR = 1'b0; IN = 4'h0;
    load_checked("load", CFG_A);
    IN = 4'b0001;
    #1;
    n_chk++;
    if (O[0] !== 1'b1) begin
      n_err++;
      $display("FAIL comb_in1: O0=%b, want 1", O[0]);
    end
    IN = 4'b0011;
    #1;
    n_chk++;
    if (O[0] !== 1'b0 || O !== m_out()) begin
      n_err++;
      $display("FAIL comb_in3: O=%b, want %b (O0=0)", O, m_out());
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    IN = 4'h0; CE = 1'b1; SR = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      else #1;
      n_chk++;
      if (O[1] !== exp_seq[j] || O !== m_out()) begin
        n_err++;
        $display("FAIL toggle%0d: O=%b, want O1=%b model %b",
                 j, O, exp_seq[j], m_out());
      end
    end
    CE = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if (O[1] !== 1'b1) begin
        n_err++;
        $display("FAIL hold%0d: O1=%b, want 1", j, O[1]);
      end
    end
  endtask

  task automatic test_srmode();
    CE = 1'b0; SR = 1'b0; IN = 4'h5;
    load(CFG_B);
    SR = 1'b1; CE = 1'b1;
    tick();
    n_chk++;
    if (O !== 2'b11 || O !== m_out()) begin
      n_err++;
      $display("FAIL sr_set: O=%b, want 11", O);
    end
    CE = 1'b0;
    load(CFG_C);
    SR = 1'b1; CE = 1'b1;
    tick();
    n_chk++;
    if (O[1] !== 1'b0 || O !== m_out()) begin
      n_err++;
      $display("FAIL sr_clr: O=%b, want O1=0 model %b", O, m_out());
    end
    SR = 1'b0;
    tick();
    n_chk++;
    if (O[1] !== 1'b1) begin
      n_err++;
      $display("FAIL sr_release: O1=%b, want 1", O[1]);
    end
    CE = 1'b0;
  endtask

  task automatic test_abort();
    for (int b = 39; b >= 30; b--) begin
      CFG_EN = 1'b1;
      CFG_DIN = CFG_B[b];
      tick();
    end
    CFG_EN = 1'b0;
    CE = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if (CFG_DONE !== 1'b0 || O !== 2'b00) begin
        n_err++;
        $display("FAIL abort%0d: done=%b O=%b, want 0 00", j, CFG_DONE, O);
      end
    end
    CE = 1'b0;
    load_checked("reload", CFG_A);
  endtask

  task automatic test_reconfig_active();
    IN = 4'h0; CE = 1'b1; SR = 1'b0;
    tick();
    CE = 1'b0;
    n_chk++;
    if (O[1] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reconfig: O1=%b, want 1", O[1]);
    end
    for (int b = 39; b >= 0; b--) begin
      n_chk++;
      if (CFG_DOUT !== CFG_A[b]) begin
        n_err++;
        $display("FAIL dout_replay%0d: dout=%b, want %b", b, CFG_DOUT, CFG_A[b]);
      end
      CFG_EN = 1'b1;
      CFG_DIN = CFG_B[b];
      tick();
      if (b == 39) begin
        n_chk++;
        if (CFG_DONE !== 1'b0 || O !== 2'b00) begin
          n_err++;
          $display("FAIL reconfig_drop: done=%b O=%b, want 0 00", CFG_DONE, O);
        end
      end
    end
    CFG_EN = 1'b0;
    #1;
    n_chk++;
    if (CFG_DONE !== 1'b1 || O !== 2'b01 || O !== m_out()) begin
      n_err++;
      $display("FAIL reconfig_qclr: done=%b O=%b, want 1 01", CFG_DONE, O);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int b = 39; b >= 25; b--) begin
      CFG_EN = 1'b1;
      CFG_DIN = CFG_C[b];
      tick();
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    CFG_EN = 1'b0;
    n_chk++;
    if ({O, CFG_DONE, CFG_DOUT} !== 4'b0000) begin
      n_err++;
      $display("FAIL midload_reset: O=%b done=%b dout=%b, want 00 0 0",
               O, CFG_DONE, CFG_DOUT);
    end
    load_checked("after_reset", CFG_C);
  endtask

  task automatic test_random();
    logic [39:0] v;
    for (int it = 0; it < 8; it++) begin
      v = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 38)); b++) begin
          CFG_EN = 1'b1;
          CFG_DIN = 1'($urandom);
          tick();
        end
        CFG_EN = 1'b0;
        tick();
      end
      load(v);
      for (int c = 0; c < 40; c++) begin
        IN = 4'($urandom);
        CE = ($urandom_range(0, 3) != 0);
        SR = ($urandom_range(0, 2) == 0);
        #1;
        n_chk++;
        if (O !== m_out()) begin
          n_err++;
          $display("FAIL rnd_comb it%0d c%0d: O=%b, want %b", it, c, O, m_out());
        end
        tick();
        n_chk++;
        if ({O, CFG_DONE, CFG_DOUT} !== {m_out(), m_done, m_cfg[39]}) begin
          n_err++;
          $display("FAIL rnd_reg it%0d c%0d: O=%b done=%b dout=%b, want %b %b %b",
                   it, c, O, CFG_DONE, CFG_DOUT, m_out(), m_done, m_cfg[39]);
        end
      end
      CE = 1'b0;
      SR = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_comb();
    test_toggle();
    test_srmode();
    test_abort();
    test_reconfig_active();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
